// File: rtl/restoring_divider4.sv
// Sequential unsigned restoring divider: one quotient bit per clock.
// Each iteration shifts {R,Q} left, trial-subtracts the divisor from R and
// either keeps the difference (quotient bit 1) or restores R (quotient bit 0).
// A zero divisor short-circuits straight to DONE with an all-ones quotient.
module restoring_divider4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  // Working registers: dividend/quotient shift register, divisor, partial remainder
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH:0]   r_reg;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   t_diff;
  logic             q_bit;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;
  logic             accept;

  // Trial subtraction in WIDTH+1 bits; a set MSB means the divisor did not fit
  function automatic logic [WIDTH:0] trial_sub(input logic [WIDTH:0]   r,
                                               input logic [WIDTH-1:0] d);
    return r - {1'b0, d};
  endfunction

  // A new operation may start whenever no iterations are in flight
  assign accept = start && (state != S_RUN);
  assign busy   = (state == S_RUN);
  assign done   = (state == S_DONE);

  // One restoring-division step computed from the current working registers
  always_comb begin
    r_shift = (r_reg << 1) | {{WIDTH{1'b0}}, q_reg[WIDTH-1]};
    t_diff  = trial_sub(r_shift, d_reg);
    q_bit   = ~t_diff[WIDTH];
    r_next  = q_bit ? t_diff : r_shift;
    q_next  = {q_reg[WIDTH-2:0], q_bit};
  end

  // Control FSM, iteration counter and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            cnt <= '0;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              state       <= S_DONE;
            end else begin
              div_by_zero <= 1'b0;
              state       <= S_RUN;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_ITER) begin
            quotient  <= q_next;
            remainder <= r_next[WIDTH-1:0];
            state     <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath registers: loaded on accept, stepped once per RUN cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      q_reg <= dividend;
      d_reg <= divisor;
      r_reg <= '0;
    end else if (state == S_RUN) begin
      q_reg <= q_next;
      r_reg <= r_next;
    end
  end

endmodule

// File: tb/tb_restoring_divider4.sv
// Self-checking bench for restoring_divider4: vector table, hand-written
// corner sequences, back-to-back exhaustive sweep and randomized operations.
module tb_restoring_divider4;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  restoring_divider4 #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer division, zero divisor yields all-ones / dividend
  function automatic void ref_div(input int a, input int b,
                                  output int q, output int r, output int z);
    if (b == 0) begin
      q = (1 << W) - 1;
      r = a;
      z = 1;
    end else begin
      q = a / b;
      r = a % b;
      z = 0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start one operation from IDLE and check timing, busy profile and result
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input int eq, input int er, input int ez,
                       input bit junk, input string tag);
    int off;
    int busy_n;
    bit got;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    tick();
    start    = 1'b0;
    dividend = 4'($urandom);
    divisor  = 4'($urandom);
    off = 0; busy_n = 0; got = 1'b0;
    while (off <= 12) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) busy_n++;
      if (junk && busy) begin
        start    = 1'($urandom_range(0, 1));
        dividend = 4'($urandom);
        divisor  = 4'($urandom);
      end
      tick();
      start = 1'b0;
      off++;
    end
    check({tag, " done seen"}, int'(got), 1);
    if (got) begin
      check({tag, " latency"}, off, (b == 0) ? 0 : W);
      check({tag, " busy cycles"}, busy_n, (b == 0) ? 0 : W);
      check({tag, " busy in done"}, int'(busy), 0);
      check({tag, " quotient"}, int'(quotient), eq);
      check({tag, " remainder"}, int'(remainder), er);
      check({tag, " div_by_zero"}, int'(div_by_zero), ez);
      tick();
      check({tag, " done pulse width"}, int'(done), 0);
      check({tag, " quotient hold"}, int'(quotient), eq);
    end
  endtask

  vec_t vecs[7];

  initial begin
    int q, r, z;
    int off, n_done, prev_t, cap_q, cap_r;
    bit got;

    vecs[0] = '{a: 4'd13, b: 4'd3,  q: 4'd4,  r: 4'd1, z: 1'b0};
    vecs[1] = '{a: 4'd15, b: 4'd1,  q: 4'd15, r: 4'd0, z: 1'b0};
    vecs[2] = '{a: 4'd2,  b: 4'd7,  q: 4'd0,  r: 4'd2, z: 1'b0};
    vecs[3] = '{a: 4'd0,  b: 4'd5,  q: 4'd0,  r: 4'd0, z: 1'b0};
    vecs[4] = '{a: 4'd15, b: 4'd15, q: 4'd1,  r: 4'd0, z: 1'b0};
    vecs[5] = '{a: 4'd9,  b: 4'd0,  q: 4'hF,  r: 4'd9, z: 1'b1};
    vecs[6] = '{a: 4'd6,  b: 4'd2,  q: 4'd3,  r: 4'd0, z: 1'b0};

    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    tick();
    tick();
    reset = 1'b0;
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset quotient", int'(quotient), 0);
    check("reset remainder", int'(remainder), 0);
    check("reset div_by_zero", int'(div_by_zero), 0);

    // Table of hand-derived vectors, including 9/0 followed by 6/2
    for (int i = 0; i < 7; i++)
      do_op(vecs[i].a, vecs[i].b, int'(vecs[i].q), int'(vecs[i].r),
            int'(vecs[i].z), 1'b0, $sformatf("vec%0d", i));

    // 14/4 with a 7/7 start pulsed mid-RUN: must be ignored
    start = 1'b1; dividend = 4'd14; divisor = 4'd4;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; dividend = 4'd7; divisor = 4'd7;
    tick();
    start = 1'b0;
    n_done = 0; cap_q = -1; cap_r = -1; off = -1;
    for (int c = 2; c < 14; c++) begin
      if (done) begin
        n_done++;
        cap_q = int'(quotient);
        cap_r = int'(remainder);
        if (off < 0) off = c;
      end
      tick();
    end
    check("midrun done count", n_done, 1);
    check("midrun latency", off, W);
    check("midrun quotient", cap_q, 3);
    check("midrun remainder", cap_r, 2);

    // Reset two cycles into 11/2: operation discarded, outputs cleared
    start = 1'b1; dividend = 4'd11; divisor = 4'd2;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset busy", int'(busy), 0);
    check("midreset done", int'(done), 0);
    check("midreset quotient", int'(quotient), 0);
    check("midreset remainder", int'(remainder), 0);
    n_done = 0;
    for (int c = 0; c < 10; c++) begin
      if (done || busy) n_done++;
      tick();
    end
    check("midreset no activity", n_done, 0);

    // Reset on the same edge as start: start is dropped
    reset = 1'b1; start = 1'b1; dividend = 4'd8; divisor = 4'd3;
    tick();
    reset = 1'b0; start = 1'b0;
    n_done = 0;
    for (int c = 0; c < 8; c++) begin
      if (done || busy) n_done++;
      tick();
    end
    check("reset+start dropped", n_done, 0);

    // Exhaustive back-to-back sweep: the next start is held in each DONE cycle,
    // so successive done pulses are WIDTH+1 edges apart (1 for a zero divisor)
    prev_t = 0;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] iv;
      iv = 8'(i);
      start = 1'b1; dividend = iv[7:4]; divisor = iv[3:0];
      tick();
      start = 1'b0;
      dividend = 4'($urandom);
      divisor  = 4'($urandom);
      off = 0; got = 1'b0;
      while (off <= 12) begin
        if (done) begin
          got = 1'b1;
          break;
        end
        tick();
        off++;
      end
      check("sweep done seen", int'(got), 1);
      ref_div(int'(iv[7:4]), int'(iv[3:0]), q, r, z);
      if (int'(quotient) != q || int'(remainder) != r || int'(div_by_zero) != z)
        $display("FAIL sweep %0d/%0d: got q=%0d r=%0d z=%0d expected q=%0d r=%0d z=%0d",
                 iv[7:4], iv[3:0], quotient, remainder, div_by_zero, q, r, z);
      check("sweep quotient", int'(quotient), q);
      check("sweep remainder", int'(remainder), r);
      check("sweep div_by_zero", int'(div_by_zero), z);
      if (i > 0)
        check("sweep done spacing", cyc - prev_t, (iv[3:0] == 0) ? 1 : W + 1);
      prev_t = cyc;
    end
    tick();

    // Randomized operations with idle gaps and stray starts during RUN
    for (int i = 0; i < 200; i++) begin
      logic [W-1:0] ra, rb;
      ra = 4'($urandom);
      rb = 4'($urandom);
      if ($urandom_range(0, 7) == 0) rb = '0;
      ref_div(int'(ra), int'(rb), q, r, z);
      do_op(ra, rb, q, r, z, 1'b1, "rand");
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
